game_control: RTL and testbench
===============================

Name: game_control

Overview:
- Top-level game sequencer of the whack-a-mole design, directly upstream of the score datapath.
- Drives the 3-bit game `state` that the datapath decodes.
- Advances on the datapath's `enable_control` timeout pulse.
- Picks a pseudo-random mole hole per round with an LFSR, counts rounds, and ends the game after a fixed number of rounds.

Parameters:
- NUM_ROUNDS, 10, moles shown per game; legal range 1..255.
- LFSR_SEED, 8'hA5, LFSR value loaded at reset; a value of 0 is replaced by 8'h01.

Ports:
- clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- start  input  1  player start key, level, already synchronised; active-high
- enable_control  input  1  one-cycle timeout pulse from the datapath
- state  output  3  game state to the datapath, registered
- mole_onehot  output  4  one-hot active hole (bit n = hole n); 0 outside mole states
- round  output  8  completed mole rounds in the current game
- game_over  output  1  high while state = OVER

Behaviour:
- Reset is synchronous and active-high on clk. It sets:
  - state = IDLE (3'b000), round = 0, mole_onehot = 0, game_over = 0
  - LFSR = LFSR_SEED (or 8'h01 if the seed is 0)
  - start_q = 0, last_hole = 0
- Reset has priority over every other input, including mid-game. The next state after reset is always IDLE.
- Start edge detection:
  - start_q <= start every cycle.
  - start_pulse = start & ~start_q.
  - Holding start high gives exactly one pulse.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts every non-reset cycle regardless of state.
  - Never reaches 0.
- State encoding (fixed; the datapath depends on it): IDLE 000, WAIT 001, MOLE0 010, MOLE1 011, MOLE2 100, MOLE3 101, OVER 110. Code 111 is unreachable; if entered, go to IDLE next cycle.
- Transitions, evaluated on the registered state:
  - IDLE: start_pulse -> WAIT, round <= 0. enable_control is ignored.
  - WAIT: enable_control -> MOLE(pick).
  - Hole selection: pick = LFSR[1:0]. If pick == last_hole and round != 0, use pick+1 mod 4. last_hole <= the chosen pick. No hole repeats in consecutive rounds.
  - MOLEn: on enable_control, round <= round+1, then:
    - if round+1 == NUM_ROUNDS -> OVER
    - else -> WAIT
  - OVER: start_pulse -> IDLE. enable_control is ignored.
  - start_pulse in WAIT or MOLEn is ignored; there is no abort.
- Outputs:
  - mole_onehot: registered alongside state; equals 1<<n in MOLEn and 0 otherwise.
  - game_over: registered, high exactly when state = OVER.
- Latency:
  - An input pulse at edge k produces the new state at edge k+1.
  - enable_control is a single-cycle pulse. A held-high input advances one state per cycle; this is legal, not guarded.
- round saturates at 255. It is not cleared on OVER; it is cleared on the next game start.

Test Plan:
- Reset, then start held high for 5 cycles -> exactly one transition to WAIT (001); round = 0; stays in WAIT while enable_control = 0.
- NUM_ROUNDS=3, drive an enable_control pulse every 20 cycles -> sequence WAIT, MOLEx, WAIT, MOLEy, WAIT, MOLEz, OVER.
  - round = 3, game_over = 1.
  - mole_onehot matches state every cycle; x≠y and y≠z.
- Force LFSR_SEED=0 -> LFSR loads 8'h01; run 300 cycles -> LFSR never 0, period 255.
- enable_control pulses in IDLE and in OVER -> state unchanged. start_pulse during MOLE1 -> stays MOLE1.
- Assert Reset while in MOLE2 with round = 2 -> next edge: state 000, round 0, mole_onehot 0, game_over 0.
- In OVER, a start rising edge -> IDLE; a second rising edge -> WAIT with round reset to 0.

Source files
------------

// File: rtl/game_control.sv
// Whack-a-mole game sequencer: walks IDLE -> (WAIT -> MOLEn)* -> OVER on the
// datapath timeout pulse, choosing a non-repeating hole per round from an LFSR.
module game_control #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       start,
    input  logic       enable_control,
    output logic [2:0] state,
    output logic [3:0] mole_onehot,
    output logic [7:0] round,
    output logic       game_over
);

    // State codes are decoded by the score datapath and must not change.
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_WAIT  = 3'b001;
    localparam logic [2:0] ST_MOLE0 = 3'b010;
    localparam logic [2:0] ST_MOLE1 = 3'b011;
    localparam logic [2:0] ST_MOLE2 = 3'b100;
    localparam logic [2:0] ST_MOLE3 = 3'b101;
    localparam logic [2:0] ST_OVER  = 3'b110;

    // An all-zero seed would lock the LFSR up, so substitute 1.
    localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [8:0] ROUNDS_9 = 9'(NUM_ROUNDS);

    logic [2:0] state_q, state_d;
    logic [3:0] mole_q, mole_d;
    logic [7:0] round_q, round_d;
    logic       over_q, over_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic       start_q, start_d;
    logic [1:0] last_hole_q, last_hole_d;

    logic       start_pulse;
    logic [1:0] pick;
    logic [7:0] round_inc;
    logic [8:0] round_next;

    // Edge detect, LFSR step and next-round arithmetic.
    always_comb begin
        start_d     = start;
        start_pulse = start & ~start_q;
        // Fibonacci taps 8,6,5,4 (maximal length, period 255).
        lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        pick        = lfsr_q[1:0];
        // Bump the pick when it would repeat the previous round's hole.
        if ((lfsr_q[1:0] == last_hole_q) && (round_q != 8'd0)) begin
            pick = lfsr_q[1:0] + 2'd1;
        end
        round_inc  = (round_q == 8'hFF) ? 8'hFF : round_q + 8'd1;
        round_next = {1'b0, round_q} + 9'd1;
    end

    // Game state transitions and registered output decode.
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        last_hole_d = last_hole_q;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    state_d = ST_WAIT;
                    round_d = 8'd0;
                end
            end
            ST_WAIT: begin
                if (enable_control) begin
                    state_d     = ST_MOLE0 + {1'b0, pick};
                    last_hole_d = pick;
                end
            end
            ST_MOLE0, ST_MOLE1, ST_MOLE2, ST_MOLE3: begin
                if (enable_control) begin
                    round_d = round_inc;
                    state_d = (round_next == ROUNDS_9) ? ST_OVER : ST_WAIT;
                end
            end
            ST_OVER: begin
                if (start_pulse) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_MOLE0: mole_d = 4'b0001;
            ST_MOLE1: mole_d = 4'b0010;
            ST_MOLE2: mole_d = 4'b0100;
            ST_MOLE3: mole_d = 4'b1000;
            default:  mole_d = 4'b0000;
        endcase
        over_d = (state_d == ST_OVER);
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            mole_q      <= 4'b0000;
            round_q     <= 8'd0;
            over_q      <= 1'b0;
            lfsr_q      <= SEED_EFF;
            start_q     <= 1'b0;
            last_hole_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            mole_q      <= mole_d;
            round_q     <= round_d;
            over_q      <= over_d;
            lfsr_q      <= lfsr_d;
            start_q     <= start_d;
            last_hole_q <= last_hole_d;
        end
    end

    assign state       = state_q;
    assign mole_onehot = mole_q;
    assign round       = round_q;
    assign game_over   = over_q;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control: vector table plus multi-cycle sequences.
module tb_game_control;

    localparam logic [2:0] S_IDLE = 3'b000;
    localparam logic [2:0] S_WAIT = 3'b001;
    localparam logic [2:0] S_M2   = 3'b100;
    localparam logic [2:0] S_OVER = 3'b110;

    // kind: 0 = exact state, 1 = new mole predicted from LFSR, 2 = hold previous state
    typedef struct packed {
        logic       rst;
        logic       st;
        logic       en;
        logic [1:0] kind;
        logic [2:0] es;
        logic [7:0] er;
    } vec_t;

    logic       clk;
    logic       Reset;
    logic       start;
    logic       enable_control;
    logic [2:0] state;
    logic [3:0] mole_onehot;
    logic [7:0] round;
    logic       game_over;

    logic [2:0] state2;
    logic [3:0] mole2;
    logic [7:0] round2;
    logic       over2;

    int n_vec;
    int n_err;

    logic [7:0] m_lfsr;
    logic [1:0] m_last;
    logic [7:0] m_round;
    logic [2:0] prev_es;

    vec_t vecs [25];

    game_control #(.NUM_ROUNDS(3), .LFSR_SEED(8'hA5)) dut (
        .clk            (clk),
        .Reset          (Reset),
        .start          (start),
        .enable_control (enable_control),
        .state          (state),
        .mole_onehot    (mole_onehot),
        .round          (round),
        .game_over      (game_over)
    );

    game_control #(.NUM_ROUNDS(10), .LFSR_SEED(8'h00)) dut0 (
        .clk            (clk),
        .Reset          (Reset),
        .start          (1'b0),
        .enable_control (1'b0),
        .state          (state2),
        .mole_onehot    (mole2),
        .round          (round2),
        .game_over      (over2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic vec_t mk(input logic rst, input logic st, input logic en,
                                input logic [1:0] kind, input logic [2:0] es,
                                input logic [7:0] er);
        vec_t v;
        v.rst = rst; v.st = st; v.en = en; v.kind = kind; v.es = es; v.er = er;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: drive, clock, advance the reference model, compare all outputs.
    task automatic step(input logic rst, input logic st, input logic en,
                        input logic [1:0] kind, input logic [2:0] es,
                        input logic [7:0] er, input string tag);
        logic [1:0] pick;
        logic [2:0] exp_s;
        logic [3:0] exp_o;
        pick = m_lfsr[1:0];
        if (pick == m_last && m_round != 8'd0) pick = pick + 2'd1;
        Reset          = rst;
        start          = st;
        enable_control = en;
        @(posedge clk);
        #1;
        if (rst) begin
            m_lfsr = 8'hA5;
            m_last = 2'd0;
        end else begin
            m_lfsr = lfsr_next(m_lfsr);
            if (kind == 2'd1) m_last = pick;
        end
        case (kind)
            2'd1:    exp_s = 3'd2 + {1'b0, pick};
            2'd2:    exp_s = prev_es;
            default: exp_s = es;
        endcase
        exp_o = (exp_s >= 3'd2 && exp_s <= 3'd5) ? (4'b0001 << (exp_s - 3'd2)) : 4'b0000;
        check(tag, {16'd0, state, mole_onehot, round, game_over},
              {16'd0, exp_s, exp_o, er, (exp_s == S_OVER)});
        prev_es = exp_s;
        m_round = er;
    endtask

    logic [2:0] moles [3];
    int         period;

    initial begin
        n_vec = 0;
        n_err = 0;
        m_lfsr = 8'h00;
        m_last = 2'd0;
        m_round = 8'd0;
        prev_es = S_IDLE;
        Reset = 1'b1;
        start = 1'b0;
        enable_control = 1'b0;

        vecs[0]  = mk(1, 0, 0, 0, S_IDLE, 0);
        vecs[1]  = mk(0, 0, 1, 0, S_IDLE, 0);   // enable ignored in IDLE
        vecs[2]  = mk(0, 1, 0, 0, S_WAIT, 0);
        vecs[3]  = mk(0, 1, 0, 0, S_WAIT, 0);   // start held: no second pulse
        vecs[4]  = mk(0, 1, 0, 0, S_WAIT, 0);
        vecs[5]  = mk(0, 1, 0, 0, S_WAIT, 0);
        vecs[6]  = mk(0, 1, 0, 0, S_WAIT, 0);
        vecs[7]  = mk(0, 0, 0, 0, S_WAIT, 0);
        vecs[8]  = mk(0, 0, 0, 0, S_WAIT, 0);
        vecs[9]  = mk(0, 0, 1, 1, 3'd0, 0);
        vecs[10] = mk(0, 0, 0, 2, 3'd0, 0);
        vecs[11] = mk(0, 1, 0, 2, 3'd0, 0);     // start in a mole state ignored
        vecs[12] = mk(0, 0, 1, 0, S_WAIT, 1);
        vecs[13] = mk(0, 0, 1, 1, 3'd0, 1);     // held enable: one state per cycle
        vecs[14] = mk(0, 0, 1, 0, S_WAIT, 2);
        vecs[15] = mk(0, 0, 1, 1, 3'd0, 2);
        vecs[16] = mk(0, 0, 1, 0, S_OVER, 3);
        vecs[17] = mk(0, 0, 1, 0, S_OVER, 3);   // enable ignored in OVER
        vecs[18] = mk(0, 0, 0, 0, S_OVER, 3);
        vecs[19] = mk(0, 1, 0, 0, S_IDLE, 3);   // round kept after OVER
        vecs[20] = mk(0, 1, 0, 0, S_IDLE, 3);
        vecs[21] = mk(0, 0, 0, 0, S_IDLE, 3);
        vecs[22] = mk(0, 1, 0, 0, S_WAIT, 0);   // new game clears round
        vecs[23] = mk(0, 0, 1, 1, 3'd0, 0);
        vecs[24] = mk(1, 0, 1, 0, S_IDLE, 0);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].en, vecs[i].kind, vecs[i].es, vecs[i].er,
                 $sformatf("vec%0d", i));
        end

        // Full game with a timeout pulse every 20 cycles.
        step(1, 0, 0, 0, S_IDLE, 0, "g20_reset");
        step(0, 1, 0, 0, S_WAIT, 0, "g20_start");
        for (int r = 0; r < 3; r++) begin
            repeat (19) step(0, 0, 0, 0, S_WAIT, 8'(r), $sformatf("g20_wait%0d", r));
            step(0, 0, 1, 1, 3'd0, 8'(r), $sformatf("g20_mole%0d", r));
            moles[r] = state;
            repeat (19) step(0, 0, 0, 2, 3'd0, 8'(r), $sformatf("g20_hold%0d", r));
            if (r == 2) step(0, 0, 1, 0, S_OVER, 3, "g20_over");
            else        step(0, 0, 1, 0, S_WAIT, 8'(r + 1), $sformatf("g20_next%0d", r));
        end
        check("hole_x_ne_y", 32'(moles[0] != moles[1]), 32'd1);
        check("hole_y_ne_z", 32'(moles[1] != moles[2]), 32'd1);
        step(0, 1, 0, 0, S_IDLE, 3, "over_to_idle");
        step(0, 0, 0, 0, S_IDLE, 3, "idle_hold");
        step(0, 1, 0, 0, S_WAIT, 0, "idle_to_wait");

        // Reset during the last mole of a game, preferring hole 2 (MOLE2).
        for (int t = 0; t < 40; t++) begin
            step(1, 0, 0, 0, S_IDLE, 0, "mr_reset");
            for (int k = 0; k < t; k++) step(0, 0, 0, 0, S_IDLE, 0, "mr_idle");
            step(0, 1, 0, 0, S_WAIT, 0, "mr_start");
            step(0, 0, 1, 1, 3'd0, 0, "mr_m0");
            step(0, 0, 1, 0, S_WAIT, 1, "mr_w1");
            step(0, 0, 1, 1, 3'd0, 1, "mr_m1");
            step(0, 0, 1, 0, S_WAIT, 2, "mr_w2");
            step(0, 0, 1, 1, 3'd0, 2, "mr_m2");
            if (state == S_M2 || t == 39) begin
                step(1, 0, 1, 0, S_IDLE, 0, "mid_game_reset");
                break;
            end
        end

        // Zero seed substitutes 1; LFSR never zero, returns to 1 after 255 steps.
        step(1, 0, 0, 0, S_IDLE, 0, "seed0_reset");
        check("seed0_load", 32'(dut0.lfsr_q), 32'h01);
        period = 0;
        for (int i = 1; i <= 300; i++) begin
            step(0, 0, 0, 0, S_IDLE, 0, "seed0_idle");
            check("lfsr_nonzero", 32'(dut0.lfsr_q != 8'h00), 32'd1);
            if (dut0.lfsr_q == 8'h01 && period == 0) period = i;
        end
        check("lfsr_period", 32'(period), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
